// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing the single L1-facing L2 port between two requesters.
// Optional watchdog abort is compiled in when L2_ARB_TIMEOUT_EN is defined.
module l2_port_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 11,
    parameter int BLOCK_SIZE     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            p0_addr,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] p0_data_in,
    input  logic                             p0_read,
    input  logic                             p0_write,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] p0_data_out,
    output logic                             p0_ready,
    output logic                             p0_hit,
    output logic                             p0_error,
    input  logic [ADDR_WIDTH-1:0]            p1_addr,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] p1_data_in,
    input  logic                             p1_read,
    input  logic                             p1_write,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] p1_data_out,
    output logic                             p1_ready,
    output logic                             p1_hit,
    output logic                             p1_error,
    output logic [ADDR_WIDTH-1:0]            l2_addr,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_data_out,
    output logic                             l2_read,
    output logic                             l2_write,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_data_in,
    input  logic                             l2_ready,
    input  logic                             l2_hit
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic   req0;
    logic   req1;
    logic   winner;
    logic   grant;
    logic   priority_port;
    logic   accept;
    logic   complete;
    logic   abort;
    logic   watchdog_expired;

    assign req0 = p0_read | p0_write;
    assign req1 = p1_read | p1_write;

    // On a conflict the port not served last wins; a lone requester always wins.
    assign winner = (req0 && req1) ? priority_port : req1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    accept     = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (l2_ready) begin
                    complete   = 1'b1;
                    next_state = DONE;
                end else if (watchdog_expired) begin
                    abort      = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Captured command stays on the L2 bus for the whole transaction; write beats read.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant         <= 1'b0;
            priority_port <= 1'b0;
            l2_addr       <= '0;
            l2_data_out   <= '0;
            l2_read       <= 1'b0;
            l2_write      <= 1'b0;
            p0_data_out   <= '0;
            p0_hit        <= 1'b0;
            p0_ready      <= 1'b0;
            p1_data_out   <= '0;
            p1_hit        <= 1'b0;
            p1_ready      <= 1'b0;
        end else begin
            p0_ready <= 1'b0;
            p1_ready <= 1'b0;
            if (accept) begin
                grant       <= winner;
                l2_addr     <= winner ? p1_addr : p0_addr;
                l2_data_out <= winner ? p1_data_in : p0_data_in;
                l2_write    <= winner ? p1_write : p0_write;
                l2_read     <= winner ? (p1_read & ~p1_write) : (p0_read & ~p0_write);
            end
            if (complete) begin
                if (grant) begin
                    p1_data_out <= l2_data_in;
                    p1_hit      <= l2_hit;
                    p1_ready    <= 1'b1;
                end else begin
                    p0_data_out <= l2_data_in;
                    p0_hit      <= l2_hit;
                    p0_ready    <= 1'b1;
                end
            end
            if (complete || abort) begin
                l2_read       <= 1'b0;
                l2_write      <= 1'b0;
                priority_port <= ~grant;
            end
        end
    end

`ifdef L2_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_count;

    // Abort fires in the BUSY cycle whose missing ready brings the count to the limit.
    assign watchdog_expired = (wd_count == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_count <= '0;
            p0_error <= 1'b0;
            p1_error <= 1'b0;
        end else begin
            p0_error <= 1'b0;
            p1_error <= 1'b0;
            if (accept) begin
                wd_count <= '0;
            end else if ((state == BUSY) && !l2_ready) begin
                wd_count <= wd_count + 1'b1;
            end
            if (abort) begin
                p0_error <= ~grant;
                p1_error <= grant;
            end
        end
    end
`else
    logic [31:0] unused_timeout;

    assign unused_timeout   = TIMEOUT_CYCLES;
    assign watchdog_expired = 1'b0;
    assign p0_error         = 1'b0;
    assign p1_error         = 1'b0;
`endif

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Randomized bench for l2_port_arbiter against a transaction-level model of the arbiter.
module tb_l2_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 11;
    localparam int BS = 4;
    localparam int BW = BS * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [BW-1:0] p0_data_in, p1_data_in;
    logic          p0_read, p0_write, p1_read, p1_write;
    logic [BW-1:0] p0_data_out, p1_data_out;
    logic          p0_ready, p0_hit, p0_error, p1_ready, p1_hit, p1_error;
    logic [AW-1:0] l2_addr;
    logic [BW-1:0] l2_data_out, l2_data_in;
    logic          l2_read, l2_write, l2_ready, l2_hit;

    l2_port_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .TIMEOUT_CYCLES(255)
    ) dut (
        .clk(clk), .rst(rst),
        .p0_addr(p0_addr), .p0_data_in(p0_data_in), .p0_read(p0_read), .p0_write(p0_write),
        .p0_data_out(p0_data_out), .p0_ready(p0_ready), .p0_hit(p0_hit), .p0_error(p0_error),
        .p1_addr(p1_addr), .p1_data_in(p1_data_in), .p1_read(p1_read), .p1_write(p1_write),
        .p1_data_out(p1_data_out), .p1_ready(p1_ready), .p1_hit(p1_hit), .p1_error(p1_error),
        .l2_addr(l2_addr), .l2_data_out(l2_data_out), .l2_read(l2_read), .l2_write(l2_write),
        .l2_data_in(l2_data_in), .l2_ready(l2_ready), .l2_hit(l2_hit)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Requester intent: each port holds one request until its ready pulse.
    bit            r_act[2];
    logic [AW-1:0] r_addr[2];
    logic [BW-1:0] r_data[2];
    bit            r_rd[2];
    bit            r_wr[2];

    // Expected DUT-visible state after the most recent clock edge.
    bit            m_busy = 0;
    bit            m_grant = 0;
    bit            m_settle = 0;
    bit            m_fav = 0;
    int            l2_cnt = 0;
    logic [AW-1:0] exp_l2_addr = '0;
    logic [BW-1:0] exp_l2_data = '0;
    bit            exp_l2_rd = 0;
    bit            exp_l2_wr = 0;
    bit            exp_rdy[2];
    logic [BW-1:0] exp_dout[2];
    bit            exp_hit[2];
    int            grants[2];

    function automatic logic [BW-1:0] randBlock();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic checkOutput(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("l2_read", BW'(l2_read), BW'(exp_l2_rd));
        checkOutput("l2_write", BW'(l2_write), BW'(exp_l2_wr));
        checkOutput("l2_addr", BW'(l2_addr), BW'(exp_l2_addr));
        checkOutput("l2_data_out", l2_data_out, exp_l2_data);
        checkOutput("p0_ready", BW'(p0_ready), BW'(exp_rdy[0]));
        checkOutput("p1_ready", BW'(p1_ready), BW'(exp_rdy[1]));
        checkOutput("p0_data_out", p0_data_out, exp_dout[0]);
        checkOutput("p1_data_out", p1_data_out, exp_dout[1]);
        checkOutput("p0_hit", BW'(p0_hit), BW'(exp_hit[0]));
        checkOutput("p1_hit", BW'(p1_hit), BW'(exp_hit[1]));
        checkOutput("p0_error", BW'(p0_error), '0);
        checkOutput("p1_error", BW'(p1_error), '0);
    endtask

    // mode 0: sporadic random requests, 1: both ports saturate, 2: no new requests
    task automatic applyStimulus(input bit do_rst, input int mode);
        bit            req[2];
        bit            g;
        logic [BW-1:0] rsp;
        bit            rsp_hit;
        for (int n = 0; n < 2; n++) begin
            if (exp_rdy[n]) r_act[n] = 0;
            if (!r_act[n] && (mode == 1 || (mode == 0 && $urandom_range(0, 3) == 0))) begin
                int kind;
                kind      = $urandom_range(0, 2);
                r_act[n]  = 1;
                r_addr[n] = AW'($urandom());
                r_data[n] = randBlock();
                r_rd[n]   = (kind != 1);
                r_wr[n]   = (kind != 0);
            end
            if (do_rst) r_act[n] = 0;
        end
        rst        = do_rst;
        p0_addr    = r_act[0] ? r_addr[0] : AW'($urandom());
        p0_data_in = r_act[0] ? r_data[0] : randBlock();
        p0_read    = r_act[0] & r_rd[0];
        p0_write   = r_act[0] & r_wr[0];
        p1_addr    = r_act[1] ? r_addr[1] : AW'($urandom());
        p1_data_in = r_act[1] ? r_data[1] : randBlock();
        p1_read    = r_act[1] & r_rd[1];
        p1_write   = r_act[1] & r_wr[1];

        rsp     = randBlock();
        rsp_hit = $urandom_range(0, 1);
        l2_ready = 1'b0;
        if (!do_rst) begin
            if (m_busy) begin
                if (l2_cnt == 0) l2_ready = 1'b1;
                else l2_cnt--;
            end else if ($urandom_range(0, 5) == 0) begin
                l2_ready = 1'b1;
            end
        end
        l2_data_in = rsp;
        l2_hit     = rsp_hit;

        exp_rdy[0] = 0;
        exp_rdy[1] = 0;
        if (do_rst) begin
            m_busy = 0; m_settle = 0; m_fav = 0;
            exp_l2_addr = '0; exp_l2_data = '0; exp_l2_rd = 0; exp_l2_wr = 0;
            exp_dout[0] = '0; exp_dout[1] = '0; exp_hit[0] = 0; exp_hit[1] = 0;
        end else if (m_busy) begin
            if (l2_ready) begin
                exp_rdy[m_grant]  = 1;
                exp_dout[m_grant] = rsp;
                exp_hit[m_grant]  = rsp_hit;
                exp_l2_rd = 0;
                exp_l2_wr = 0;
                m_fav     = !m_grant;
                m_busy    = 0;
                m_settle  = 1;
            end
        end else if (m_settle) begin
            m_settle = 0;
        end else begin
            req[0] = p0_read | p0_write;
            req[1] = p1_read | p1_write;
            if (req[0] || req[1]) begin
                g = (req[0] && req[1]) ? m_fav : req[1];
                exp_l2_addr = g ? p1_addr : p0_addr;
                exp_l2_data = g ? p1_data_in : p0_data_in;
                exp_l2_wr   = g ? p1_write : p0_write;
                exp_l2_rd   = !exp_l2_wr;
                m_grant     = g;
                m_busy      = 1;
                l2_cnt      = $urandom_range(0, 4);
                grants[g]++;
            end
        end
    endtask

    task automatic step(input bit do_rst, input int mode);
        @(negedge clk);
        checkAll();
        applyStimulus(do_rst, mode);
    endtask

    initial begin
        bit reached;
        rst = 1'b1;
        p0_addr = '0; p0_data_in = '0; p0_read = 0; p0_write = 0;
        p1_addr = '0; p1_data_in = '0; p1_read = 0; p1_write = 0;
        l2_data_in = '0; l2_ready = 0; l2_hit = 0;
        for (int n = 0; n < 2; n++) begin
            r_act[n] = 0; exp_rdy[n] = 0; exp_dout[n] = '0; exp_hit[n] = 0; grants[n] = 0;
        end
        for (int i = 0; i < 3; i++) step(1'b1, 2);

        // First conflict after reset: p0 read 0x040 against p1 write 0x080.
        r_act[0] = 1; r_addr[0] = 11'h040; r_data[0] = randBlock(); r_rd[0] = 1; r_wr[0] = 0;
        r_act[1] = 1; r_addr[1] = 11'h080; r_data[1] = randBlock(); r_rd[1] = 0; r_wr[1] = 1;
        step(1'b0, 2);
        checkOutput("first_grant_p0", BW'(m_grant), '0);
        for (int i = 0; i < 30; i++) step(1'b0, 2);
        checkOutput("both_served", BW'(grants[0] + grants[1]), BW'(2));

        for (int i = 0; i < 400; i++) step(1'b0, 0);
        for (int i = 0; i < 300; i++) step(1'b0, 1);

        reached = 0;
        for (int i = 0; i < 50 && !reached; i++) begin
            step(1'b0, 1);
            reached = m_busy;
        end
        checkOutput("reach_busy_for_reset", BW'(reached), BW'(1));
        step(1'b1, 2);
        for (int i = 0; i < 400; i++) step(1'b0, 0);
        step(1'b0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
